// File: rtl/pipeline_run_ctrl.sv
// Run controller for the 5-stage RISC-V pipeline: sequences core reset release,
// counts RUN cycles and retires, and halts on EBREAK, self-loop or timeout.
module pipeline_run_ctrl #(
  parameter int XLEN       = 32,
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 4,
  parameter int MAX_CYCLES = 1000,
  parameter int LOOP_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire_valid,
  input  logic [XLEN-1:0]  retire_pc,
  input  logic [31:0]      retire_instr,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] STAT_NONE    = 2'b00;
  localparam logic [1:0] STAT_EBREAK  = 2'b01;
  localparam logic [1:0] STAT_LOOP    = 2'b10;
  localparam logic [1:0] STAT_TIMEOUT = 2'b11;

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int LOOP_W = $clog2(LOOP_LIMIT + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
  localparam logic [LOOP_W-1:0] LOOP_MAX   = LOOP_W'(LOOP_LIMIT);
  localparam logic [CNT_W-1:0]  TIMEOUT_AT = CNT_W'(MAX_CYCLES - 1);
  localparam logic [31:0]       EBREAK     = 32'h0010_0073;

  logic [1:0]        r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [LOOP_W-1:0] r_loop_cnt;
  logic [XLEN-1:0]   r_last_pc;
  logic              r_core_rst;
  logic              r_running;
  logic              r_done;
  logic [1:0]        r_status;
  logic [CNT_W-1:0]  r_cycle_count;
  logic [CNT_W-1:0]  r_retire_count;

  logic              w_is_ebreak;
  logic              w_is_loop;
  logic              w_is_timeout;
  logic [LOOP_W-1:0] w_loop_next;
  logic [CNT_W-1:0]  w_cycle_inc;
  logic [CNT_W-1:0]  w_retire_inc;
  logic [1:0]        w_stop_code;

  // Loop streak only advances while running, so it never exceeds LOOP_LIMIT-1 here.
  assign w_loop_next  = (retire_pc == r_last_pc) ? (r_loop_cnt + LOOP_W'(1)) : LOOP_W'(1);
  assign w_is_ebreak  = retire_valid && (retire_instr == EBREAK);
  assign w_is_loop    = retire_valid && (w_loop_next == LOOP_MAX);
  assign w_is_timeout = (MAX_CYCLES != 0) && (r_cycle_count == TIMEOUT_AT);
  assign w_cycle_inc  = (r_cycle_count == '1) ? r_cycle_count : r_cycle_count + CNT_W'(1);
  assign w_retire_inc = (r_retire_count == '1) ? r_retire_count : r_retire_count + CNT_W'(1);

  always_comb begin
    w_stop_code = STAT_NONE;
    if (w_is_ebreak)       w_stop_code = STAT_EBREAK;
    else if (w_is_loop)    w_stop_code = STAT_LOOP;
    else if (w_is_timeout) w_stop_code = STAT_TIMEOUT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_HOLD;
      r_hold_cnt     <= '0;
      r_loop_cnt     <= '0;
      r_last_pc      <= '0;
      r_core_rst     <= 1'b1;
      r_running      <= 1'b0;
      r_done         <= 1'b0;
      r_status       <= STAT_NONE;
      r_cycle_count  <= '0;
      r_retire_count <= '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state    <= ST_RUN;
            r_core_rst <= 1'b0;
            r_running  <= 1'b1;
            r_loop_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          // The terminating cycle and retire are both counted before freezing.
          r_cycle_count <= w_cycle_inc;
          if (retire_valid) begin
            r_retire_count <= w_retire_inc;
            r_loop_cnt     <= w_loop_next;
            r_last_pc      <= retire_pc;
          end
          if (w_stop_code != STAT_NONE) begin
            r_state   <= ST_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_status  <= w_stop_code;
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state    <= ST_HOLD;
          r_hold_cnt <= '0;
          r_core_rst <= 1'b1;
          r_running  <= 1'b0;
        end
      endcase
    end
  end

  assign core_rst     = r_core_rst;
  assign running      = r_running;
  assign done         = r_done;
  assign status       = r_status;
  assign cycle_count  = r_cycle_count;
  assign retire_count = r_retire_count;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl: directed and random retire streams scored against
// a run-history model; one instance with a 20-cycle timeout, one with none.
module tb_pipeline_run_ctrl;

  localparam int RST_N  = 4;
  localparam int LOOP_N = 8;
  localparam int MAX_A  = 20;
  localparam int MAX_B  = 0;
  localparam logic [31:0] EBRK = 32'h0010_0073;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rv = 1'b0;
  logic [31:0] rpc = '0;
  logic [31:0] rinstr = '0;

  logic        core_rst_a, running_a, done_a, core_rst_b, running_b, done_b;
  logic [1:0]  status_a, status_b;
  logic [31:0] cyc_a, ret_a, cyc_b, ret_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipeline_run_ctrl #(.XLEN(32), .CNT_W(32), .RST_CYCLES(RST_N), .MAX_CYCLES(MAX_A),
                      .LOOP_LIMIT(LOOP_N)) dut_a (
    .clk(clk), .rst(rst), .retire_valid(rv), .retire_pc(rpc), .retire_instr(rinstr),
    .core_rst(core_rst_a), .running(running_a), .done(done_a), .status(status_a),
    .cycle_count(cyc_a), .retire_count(ret_a));

  pipeline_run_ctrl #(.XLEN(32), .CNT_W(32), .RST_CYCLES(RST_N), .MAX_CYCLES(MAX_B),
                      .LOOP_LIMIT(LOOP_N)) dut_b (
    .clk(clk), .rst(rst), .retire_valid(rv), .retire_pc(rpc), .retire_instr(rinstr),
    .core_rst(core_rst_b), .running(running_b), .done(done_b), .status(status_b),
    .cycle_count(cyc_b), .retire_count(ret_b));

  typedef struct {
    logic        core_rst;
    logic        running;
    logic        done;
    logic [1:0]  status;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // Model: edges since release, whether the run ended, and the retire history.
  int          m_rel[2];
  bit          m_fin[2];
  logic [1:0]  m_st[2];
  longint      m_cyc[2];
  longint      m_ret[2];
  int          m_streak[2];
  logic [31:0] m_prev[2];
  int          m_max[2] = '{MAX_A, MAX_B};

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      m_rel[k] = 0; m_fin[k] = 0; m_st[k] = 2'b00; m_cyc[k] = 0;
      m_ret[k] = 0; m_streak[k] = 0; m_prev[k] = '0;
    end
  endfunction

  function automatic void m_step(input bit v, input logic [31:0] pc, input logic [31:0] instr);
    for (int k = 0; k < 2; k++) begin
      if (m_rel[k] < RST_N) begin
        m_rel[k]++;
      end else if (!m_fin[k]) begin
        bit eb, lp, to;
        if (m_cyc[k] < 64'hFFFF_FFFF) m_cyc[k]++;
        eb = v && (instr == EBRK);
        lp = 0;
        if (v) begin
          if (m_ret[k] < 64'hFFFF_FFFF) m_ret[k]++;
          m_streak[k] = (pc == m_prev[k]) ? m_streak[k] + 1 : 1;
          m_prev[k] = pc;
          lp = (m_streak[k] == LOOP_N);
        end
        to = (m_max[k] != 0) && (m_cyc[k] == m_max[k]);
        if (eb)      m_st[k] = 2'b01;
        else if (lp) m_st[k] = 2'b10;
        else if (to) m_st[k] = 2'b11;
        m_fin[k] = eb || lp || to;
      end
    end
  endfunction

  function automatic exp_t m_exp(input int k);
    exp_t e;
    e.core_rst = (m_rel[k] < RST_N);
    e.running  = (m_rel[k] >= RST_N) && !m_fin[k];
    e.done     = m_fin[k];
    e.status   = m_st[k];
    e.cyc      = m_cyc[k][31:0];
    e.ret      = m_ret[k][31:0];
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  // Drive one cycle at the falling edge and queue what the next rising edge must show.
  task automatic cyc_drive(input bit r, input bit v, input logic [31:0] pc, input logic [31:0] instr);
    @(negedge clk);
    rst = r; rv = v; rpc = pc; rinstr = instr;
    if (r) m_reset();
    else   m_step(v, pc, instr);
    qa.push_back(m_exp(0));
    qb.push_back(m_exp(1));
    if (v && !r) $display("txn t=%0t pc=%h instr=%h", $time, pc, instr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    cyc_drive(1'b1, 1'b0, 32'h0, 32'h0);
    cyc_drive(1'b1, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    exp_t ea, eb;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("a_core_rst", core_rst_a, ea.core_rst);
        chk("a_running",  running_a,  ea.running);
        chk("a_done",     done_a,     ea.done);
        chk("a_status",   status_a,   ea.status);
        chk("a_cycles",   cyc_a,      ea.cyc);
        chk("a_retires",  ret_a,      ea.ret);
        chk("b_core_rst", core_rst_b, eb.core_rst);
        chk("b_running",  running_b,  eb.running);
        chk("b_done",     done_b,     eb.done);
        chk("b_status",   status_b,   eb.status);
        chk("b_cycles",   cyc_b,      eb.cyc);
        chk("b_retires",  ret_b,      eb.ret);
      end
    end
  end

  initial begin
    logic [31:0] pc_r;
    m_reset();

    // Reset release and EBREAK after nine distinct retires.
    do_reset();
    idle(RST_N);
    for (int i = 0; i < 9; i++) cyc_drive(1'b0, 1'b1, 32'(i * 4), NOP);
    cyc_drive(1'b0, 1'b1, 32'h24, EBRK);
    after_edge();
    chk("ebreak_status", status_a, 32'd1);
    chk("ebreak_retires", ret_a, 32'd10);
    for (int i = 0; i < 3; i++) cyc_drive(1'b0, 1'b1, 32'h28, NOP);
    after_edge();
    chk("ebreak_frozen", ret_b, 32'd10);

    // Self-loop with bubbles between same-PC retires.
    do_reset();
    idle(RST_N);
    for (int i = 0; i < LOOP_N; i++) begin
      cyc_drive(1'b0, 1'b1, 32'h40, NOP);
      if (i < LOOP_N - 1) idle(1);
    end
    after_edge();
    chk("loop_status", status_a, 32'd2);
    chk("loop_retires", ret_a, 32'd8);
    idle(3);

    // A differing PC after five repeats restarts the streak.
    do_reset();
    idle(RST_N);
    for (int i = 0; i < 5; i++) cyc_drive(1'b0, 1'b1, 32'h40, NOP);
    cyc_drive(1'b0, 1'b1, 32'h44, NOP);
    for (int i = 0; i < LOOP_N - 1; i++) cyc_drive(1'b0, 1'b1, 32'h40, NOP);
    after_edge();
    chk("restart_not_done", done_a, 32'd0);
    cyc_drive(1'b0, 1'b1, 32'h40, NOP);
    after_edge();
    chk("restart_status", status_b, 32'd2);
    chk("restart_retires", ret_b, 32'd14);

    // Timeout with no retires.
    do_reset();
    idle(RST_N + MAX_A - 1);
    after_edge();
    chk("timeout_early", done_a, 32'd0);
    idle(1);
    after_edge();
    chk("timeout_status", status_a, 32'd3);
    chk("timeout_cycles", cyc_a, 32'd20);
    idle(4);

    // EBREAK on the timeout cycle wins.
    do_reset();
    idle(RST_N + MAX_A - 1);
    cyc_drive(1'b0, 1'b1, 32'h80, EBRK);
    after_edge();
    chk("collide_status", status_a, 32'd1);
    chk("collide_cycles", cyc_a, 32'd20);

    // Asynchronous reset mid-run, then the hold sequence again.
    do_reset();
    idle(RST_N + 6);
    @(posedge clk);
    #3;
    rst = 1'b1;
    m_reset();
    #1;
    chk("async_core_rst", core_rst_a, 32'd1);
    chk("async_running", running_a, 32'd0);
    chk("async_done", done_a, 32'd0);
    chk("async_cycles", cyc_a, 32'd0);
    chk("async_retires", ret_a, 32'd0);
    do_reset();
    idle(RST_N + 3);

    // Random retire streams with frequent PC repeats and occasional EBREAK.
    for (int run = 0; run < 15; run++) begin
      do_reset();
      pc_r = 32'h100;
      for (int i = 0; i < 30 + int'($urandom_range(0, 20)); i++) begin
        if ($urandom_range(0, 3) == 0) pc_r = 32'h100 + 32'($urandom_range(0, 3) * 4);
        cyc_drive(1'b0, 1'($urandom_range(0, 1)), pc_r,
                  ($urandom_range(0, 24) == 0) ? EBRK : NOP);
      end
    end

    // No timeout when disabled.
    do_reset();
    idle(RST_N + 5000);
    after_edge();
    chk("notimeout_done", done_b, 32'd0);
    chk("notimeout_cycles", cyc_b, 32'd5000);

    after_edge();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
